multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised multicycle MIPS control unit: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback over several cycles. It drives the shared-memory/single-ALU multicycle datapath and supports R-type, addi, addiu, lw, sw, beq and j. It stalls on a memory ready handshake, flags illegal opcodes, and counts retired instructions.

## Interface
- ALUCTRL_W, 4: ALUControl width. Legal range 4..6. R-type passes funct[ALUCTRL_W-1:0].
- CNT_W, 32: retired-instruction counter width.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction-register bits [31:26], stable from DECODE onward
- funct  in  6  instruction-register bits [5:0]
- zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory has completed the current read/write this cycle
- MemRead, MemWrite, IorD, IRWrite  out  1 each  memory/IR control
- RegDst, MemtoReg, RegWrite  out  1 each  register-file control
- ALUSrcA  out  1; ALUSrcB  out  2 (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2)
- ALUControl  out  ALUCTRL_W  ALU op: add 0000, addu 0001, sub 0010, zero-extended to width
- PCSrc  out  2 (00 ALU result, 01 ALUOut, 10 jump target); PCWrite  out  1
- illegal  out  1  one-cycle pulse on an unsupported opcode
- retired  out  CNT_W  count of completed instructions

## Operation
- States (enum): IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ALUWB, IMMEXE, BRANCH, JUMP.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0. Always goes to FETCH.
- FETCH: MemRead=1, ALUSrcB=01, ALUControl=add.
  - mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE.
  - mem_ready=0: hold FETCH with IRWrite=0 and PCWrite=0.
- DECODE: ALUSrcB=11, ALUControl=add (branch target). Next state by opcode:
  - 000000 → RTEXE
  - 001000, 001001 → IMMEXE
  - 100011, 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - any other opcode → illegal=1 for one cycle, go to FETCH, nothing retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=add. lw → MEMRD; sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. → FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold (MemWrite held high) until mem_ready, then → FETCH.
- RTEXE: ALUSrcA=1, ALUSrcB=00, ALUControl=funct[ALUCTRL_W-1:0]. → ALUWB.
- ALUWB: RegWrite=1, RegDst=1. → FETCH.
- IMMEXE: ALUSrcA=1, ALUSrcB=10, ALUControl=add (addi) or addu (addiu). → ALUWB with RegDst=0. A registered flag selects RegDst for ALUWB.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=sub, PCSrc=01, PCWrite=zero. → FETCH.
- JUMP: PCSrc=10, PCWrite=1. → FETCH.
- retired increments by 1 on exit from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH or JUMP.
  - Wraps from all-ones to 0 without saturating.
  - Never increments on illegal.

## Timing
- Asynchronous rst_n low: state=IDLE, retired=0, imm flag=0, so every output reads 0.
- First FETCH is one cycle after rst_n deasserts.
- Control outputs are combinational from state (plus opcode/funct/zero/mem_ready where listed). No output register.
- Cycles per instruction with mem_ready tied high: R-type 4, addi/addiu 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each cycle with mem_ready low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset asserted mid-instruction: immediate return to IDLE. A partial store is abandoned and retired is cleared.
- retired updates on the same clock edge as the transition to FETCH.

## Structure
- mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J
  - ALU code constants: ALU_ADD, ALU_ADDU, ALU_SUB
  - the state enum typedef
  - ALUSrcB/PCSrc encodings
- One sub-module, alu_decoder, is natural: it maps state-class/opcode/funct to ALUControl and is parametrised by ALUCTRL_W.
- The top level holds the state register, the imm flag and the retired counter.

## Test plan
- Reset release, mem_ready=1, IR = add (opcode 000000, funct 100000) → FETCH, DECODE, RTEXE (ALUControl=0000), ALUWB (RegWrite=1, RegDst=1); retired=1 after 4 cycles.
- lw with mem_ready low for 2 cycles in MEMRD → 7 cycles total; IorD=1 throughout MEMRD; MemtoReg=1 in MEMWB.
- beq with zero=1 → PCWrite=1, PCSrc=01 in BRANCH. Repeat with zero=0 → PCWrite=0. Both take 3 cycles and retire.
- opcode 111111 → illegal pulses exactly one cycle after DECODE, then FETCH; retired unchanged.
- CNT_W=4, 17 j instructions → retired wraps to 1. Assert rst_n low mid-MEMWR → all outputs 0 immediately, retired=0.
- ALUCTRL_W=6, R-type funct 100010 → ALUControl=100010. addiu → ALUControl=000001, RegDst=0 in ALUWB.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU codes, state and mux encodings for the multicycle MIPS control unit
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Held at the widest legal ALUControl width; users slice to their own width.
    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_ADDU = 6'b000001;
    localparam logic [5:0] ALU_SUB  = 6'b000010;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTEXE,
        ALUWB,
        IMMEXE,
        BRANCH,
        JUMP
    } state_t;

    // What kind of operation the ALU performs in the current state.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_FUNCT,
        ALU_CLS_IMM
    } alu_cls_t;

    // Successor of DECODE; FETCH marks an unsupported opcode.
    function automatic state_t decode_target(input logic [5:0] opcode);
        state_t target;
        case (opcode)
            OP_RTYPE:        target = RTEXE;
            OP_ADDI, OP_ADDIU: target = IMMEXE;
            OP_LW, OP_SW:    target = MEMADR;
            OP_BEQ:          target = BRANCH;
            OP_J:            target = JUMP;
            default:         target = FETCH;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps the state's ALU class plus opcode/funct onto ALUControl
// alu_cls     : operation class requested by the current FSM state
// opcode      : instruction opcode, picks add/addu for immediate arithmetic
// funct       : R-type function field, passed through truncated to ALUCTRL_W
// alu_control : ALU operation code, ALUCTRL_W bits
module alu_decoder
    import mips_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  alu_cls_t              alu_cls,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    output logic [ALUCTRL_W-1:0]  alu_control
);

    // Upper funct bits are legitimately ignored when ALUCTRL_W < 6.
    logic unused_funct;
    assign unused_funct = ^funct;

    always_comb begin
        alu_control = ALU_ADD[ALUCTRL_W-1:0];
        case (alu_cls)
            ALU_CLS_ADD:   alu_control = ALU_ADD[ALUCTRL_W-1:0];
            ALU_CLS_SUB:   alu_control = ALU_SUB[ALUCTRL_W-1:0];
            ALU_CLS_FUNCT: alu_control = funct[ALUCTRL_W-1:0];
            ALU_CLS_IMM:   alu_control = (opcode == OP_ADDIU) ? ALU_ADDU[ALUCTRL_W-1:0]
                                                             : ALU_ADD[ALUCTRL_W-1:0];
            default:       alu_control = ALU_ADD[ALUCTRL_W-1:0];
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM control unit for the multicycle MIPS datapath
// clk, rst_n                      : clock, asynchronous active-low reset
// opcode, funct, zero, mem_ready  : instruction fields, ALU zero flag, memory handshake
// MemRead..PCWrite                : datapath control, combinational from state
// illegal                         : high during DECODE of an unsupported opcode
// retired                         : wrapping count of completed instructions
module multicycle_control
    import mips_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  IorD,
    output logic                  IRWrite,
    output logic                  RegDst,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALUCTRL_W-1:0]  ALUControl,
    output logic [1:0]            PCSrc,
    output logic                  PCWrite,
    output logic                  illegal,
    output logic [CNT_W-1:0]      retired
);

    state_t           state_q, state_d;
    logic             imm_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    alu_cls_t         alu_cls;
    state_t           dec_target;

    assign dec_target = decode_target(opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            imm_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            // ALUWB is shared by R-type and immediate ops; remember which one led here.
            imm_q   <= (state_q == IMMEXE);
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_REG;
        alu_cls  = ALU_CLS_ADD;
        PCSrc    = PCSRC_ALU;
        PCWrite  = 1'b0;
        illegal  = 1'b0;
        retire   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Precompute the branch target while the opcode is examined.
                ALUSrcB = SRCB_IMM_SH;
                state_d = dec_target;
                illegal = (dec_target == FETCH);
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            RTEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                alu_cls = ALU_CLS_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = ~imm_q;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            IMMEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_cls = ALU_CLS_IMM;
                state_d = ALUWB;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                alu_cls = ALU_CLS_SUB;
                PCSrc   = PCSRC_ALUOUT;
                PCWrite = zero;
                retire  = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .alu_cls     (alu_cls),
        .opcode      (opcode),
        .funct       (funct),
        .alu_control (ALUControl)
    );

    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized scoreboard bench for multicycle_control
module tb_multicycle_control;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_ADDIU = 6'b001001;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;

    typedef struct packed {
        logic       memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [5:0] aluctrl;
        logic [1:0] pcsrc;
        logic       pcwrite, illegal;
        logic [3:0] retired;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [5:0] ALUControl;
    logic       PCWrite, illegal;
    logic [3:0] retired;

    outs_t exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    model_ret = 0;

    multicycle_control #(.ALUCTRL_W(6), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
        .PCWrite(PCWrite), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            outs_t e, act;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            act = {MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUControl, PCSrc, PCWrite, illegal, retired};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: got %h required %h", t, $time, act, e);
            end
        end
    end

    function automatic outs_t base();
        outs_t e = '0;
        e.retired = 4'(model_ret);
        return e;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {T_RTYPE, T_ADDI, T_ADDIU, T_LW, T_SW, T_BEQ, T_J};
    endfunction

    // One clock cycle of stimulus plus the outputs the spec requires during it.
    task automatic drive(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic mr, input outs_t e, input string tag);
        @(posedge clk);
        #1;
        rst_n = rn; opcode = op; funct = fn; zero = z; mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int fstall);
        outs_t e;
        e = base(); e.memread = 1'b1; e.alusrcb = 2'b01;
        for (int i = 0; i < fstall; i++)
            drive(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0, e, "fetch_stall");
        e.irwrite = 1'b1; e.pcwrite = 1'b1;
        drive(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), 1'b1, e, "fetch");
        e = base(); e.alusrcb = 2'b11; e.illegal = !is_legal(op);
        drive(1'b1, op, fn, 1'($urandom), 1'($urandom), e, "decode");
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fstall,
                             input int mstall, input logic z);
        outs_t e;
        fetch_decode(op, fn, fstall);
        if (!is_legal(op)) return;
        case (op)
            T_RTYPE, T_ADDI, T_ADDIU: begin
                e = base(); e.alusrca = 1'b1;
                e.alusrcb = (op == T_RTYPE) ? 2'b00 : 2'b10;
                e.aluctrl = (op == T_RTYPE) ? fn : ((op == T_ADDIU) ? 6'd1 : 6'd0);
                drive(1'b1, op, fn, 1'($urandom), 1'($urandom), e, "execute");
                e = base(); e.regwrite = 1'b1; e.regdst = (op == T_RTYPE);
                drive(1'b1, op, fn, 1'($urandom), 1'($urandom), e, "aluwb");
            end
            T_LW, T_SW: begin
                e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                drive(1'b1, op, fn, 1'($urandom), 1'($urandom), e, "memadr");
                e = base(); e.iord = 1'b1;
                if (op == T_LW) e.memread = 1'b1; else e.memwrite = 1'b1;
                for (int i = 0; i < mstall; i++)
                    drive(1'b1, op, fn, 1'($urandom), 1'b0, e, "mem_stall");
                drive(1'b1, op, fn, 1'($urandom), 1'b1, e, "mem_access");
                if (op == T_LW) begin
                    e = base(); e.regwrite = 1'b1; e.memtoreg = 1'b1;
                    drive(1'b1, op, fn, 1'($urandom), 1'($urandom), e, "memwb");
                end
            end
            T_BEQ: begin
                e = base(); e.alusrca = 1'b1; e.aluctrl = 6'd2; e.pcsrc = 2'b01; e.pcwrite = z;
                drive(1'b1, op, fn, z, 1'($urandom), e, "branch");
            end
            default: begin
                e = base(); e.pcsrc = 2'b10; e.pcwrite = 1'b1;
                drive(1'b1, op, fn, 1'($urandom), 1'($urandom), e, "jump");
            end
        endcase
        model_ret = (model_ret + 1) % 16;
    endtask

    task automatic reset_cycles(input int n);
        model_ret = 0;
        for (int i = 0; i < n; i++)
            drive(1'b0, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), base(), "reset");
        drive(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), base(), "idle");
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{T_RTYPE, T_ADDI, T_ADDIU, T_LW, T_SW, T_BEQ, T_J, 6'b111111};

        reset_cycles(2);
        run_instr(T_RTYPE, 6'b100000, 0, 0, 1'b0);
        run_instr(T_LW, 6'($urandom), 0, 2, 1'b0);
        run_instr(T_BEQ, 6'($urandom), 0, 0, 1'b1);
        run_instr(T_BEQ, 6'($urandom), 0, 0, 1'b0);
        run_instr(6'b111111, 6'($urandom), 0, 0, 1'b0);
        run_instr(T_RTYPE, 6'b100010, 0, 0, 1'b0);
        run_instr(T_ADDIU, 6'($urandom), 0, 0, 1'b0);
        run_instr(T_ADDI, 6'($urandom), 1, 0, 1'b0);
        run_instr(T_SW, 6'($urandom), 2, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int k;
            logic [5:0] op;
            k = $urandom_range(0, 8);
            op = (k == 8) ? 6'($urandom) : ops[k];
            run_instr(op, 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        // Abandon a store mid-wait: reset must clear outputs within the same cycle.
        begin
            outs_t e;
            fetch_decode(T_SW, 6'($urandom), 0);
            e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
            drive(1'b1, T_SW, 6'($urandom), 1'b0, 1'b0, e, "memadr");
            e = base(); e.memwrite = 1'b1; e.iord = 1'b1;
            drive(1'b1, T_SW, 6'($urandom), 1'b0, 1'b0, e, "mem_stall");
            reset_cycles(1);
        end

        for (int n = 0; n < 17; n++) run_instr(T_J, 6'($urandom), 0, 0, 1'b0);
        run_instr(T_RTYPE, 6'b100000, 0, 0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
